hidden_layer_accumulator: RTL and testbench
===========================================

HIDDEN_LAYER_ACCUMULATOR -- requirements
Module: hidden_layer_accumulator

Interface
REQ-001 The block SHALL have parameter INPUT_LAYER_NODES, default 10, meaning input pixel count; index width is clog2(INPUT_LAYER_NODES), minimum 1.
REQ-002 The block SHALL have parameter HIDDEN_NODES, default 4, meaning parallel hidden-node accumulators.
REQ-003 The block SHALL have parameter WEIGHT_WIDTH, default 8, meaning signed two's-complement weight width.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 16, meaning signed accumulator width, at least WEIGHT_WIDTH.
REQ-005 The block SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-low.
REQ-006 The block SHALL have ports: outputsReady in 1, upstream batch complete; queueEmpty in 1, upstream queue empty; indexOut in IDXW, head-of-queue active pixel index.
REQ-007 The block SHALL have port dequeue out 1, a one-cycle pop pulse to upstream.
REQ-008 The block SHALL have ports: weightAddr out IDXW; weightData in HIDDEN_NODES*WEIGHT_WIDTH, node k in slice k, read latency exactly 1 cycle.
REQ-009 The block SHALL have ports: sums out HIDDEN_NODES*ACC_WIDTH; resultsValid out 1; resultsAck in 1; busy out 1.

Function
REQ-010 The FSM SHALL have states IDLE, CHECK, POP, FETCH, ACCUM and DONE.
REQ-011 IDLE SHALL go to CHECK and clear all accumulators when outputsReady=1; otherwise it holds.
REQ-012 CHECK SHALL go to DONE if queueEmpty=1; otherwise it SHALL register weightAddr<=indexOut and go to POP.
REQ-013 POP SHALL assert dequeue for exactly one cycle and go to FETCH; dequeue SHALL be 0 in every other state.
REQ-014 FETCH SHALL wait one cycle for weightData and go to ACCUM.
REQ-015 ACCUM SHALL add each sign-extended weight slice k into accumulator k, then go to CHECK, giving 4 cycles per active index.
REQ-016 Addition SHALL saturate to the signed ACC_WIDTH range (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)) and never wrap.
REQ-017 DONE SHALL hold resultsValid=1 and sums stable until resultsAck=1, then return to IDLE in the next cycle.
REQ-018 resultsAck SHALL be ignored in every state except DONE.
REQ-019 An empty batch (queueEmpty=1 at the first CHECK) SHALL produce all-zero sums with resultsValid.
REQ-020 busy SHALL be 1 in every state except IDLE; outputsReady SHALL be ignored while busy.
REQ-021 The duplicate-index rule SHALL be that each dequeued entry is accumulated once, with no deduplication.

Reset
REQ-022 When reset=0 at a clock edge, the block SHALL go to IDLE with accumulators=0, sums=0, weightAddr=0, dequeue=0, resultsValid=0 and busy=0.
REQ-023 Reset mid-batch SHALL abandon the batch without a further dequeue pulse; entries remaining upstream are the upstream block's responsibility.

Configuration
REQ-024 With macro HIDDEN_RELU_EN defined, sums SHALL present max(acc,0) per node; otherwise sums SHALL present the raw signed saturated accumulators.
REQ-025 The macro SHALL affect only the sums output path; FSM timing SHALL be identical in both builds.

Structure
REQ-026 Shared package nn_pkg SHALL hold the FSM state enum, default widths, and the saturation min/max constants.
REQ-027 Sub-module sat_add SHALL implement a parameterised signed saturating adder (ACC_WIDTH + WEIGHT_WIDTH -> ACC_WIDTH), instantiated HIDDEN_NODES times.

Verification
REQ-028 Queue 2,4,5,7,9 with weight[i] node0=i, node1=-i, others 1 -> sums {27,-27,5,5} and resultsValid 21 cycles after the start edge.
REQ-029 Empty batch: outputsReady=1, queueEmpty=1 -> all sums 0, resultsValid asserted, dequeue never pulsed.
REQ-030 Saturation: 10 indices with all weights +127 and ACC_WIDTH=8 -> node sums 127, no wrap; with all weights -128 -> sums -128 without HIDDEN_RELU_EN and 0 with it.
REQ-031 Handshake: leave resultsAck low for 50 cycles -> sums stable and outputsReady ignored; pulse resultsAck -> IDLE next cycle, and a new batch accumulates from 0.
REQ-032 Drive reset=0 during the third index's FETCH -> next cycle IDLE with all outputs 0 and no extra dequeue pulse.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the hidden-layer accumulator slice:
// the controller state encoding, default geometry, and the signed
// saturation limits used by the saturating adders.
package nn_pkg;

  // Controller states for one accumulation batch.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_POP   = 3'd2,
    ST_FETCH = 3'd3,
    ST_ACCUM = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Default geometry: 10 input pixels feeding 4 hidden nodes,
  // 8-bit signed weights accumulated into 16-bit signed sums.
  localparam int DEFAULT_INPUT_LAYER_NODES = 10;
  localparam int DEFAULT_HIDDEN_NODES      = 4;
  localparam int DEFAULT_WEIGHT_WIDTH      = 8;
  localparam int DEFAULT_ACC_WIDTH         = 16;

  // Largest representable value of a signed number of the given width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative representable value of a signed number of the given width.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Saturation limits for the default accumulator width.
  localparam logic signed [63:0] DEFAULT_SAT_MAX = sat_max(DEFAULT_ACC_WIDTH);
  localparam logic signed [63:0] DEFAULT_SAT_MIN = sat_min(DEFAULT_ACC_WIDTH);

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: adds a sign-extended weight to an accumulator
// value and clamps the result to the accumulator's signed range, so a
// long run of same-sign weights pins at the limit instead of wrapping.
module sat_add
  import nn_pkg::*;
#(
  parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
  parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]    acc,
  input  logic signed [WEIGHT_WIDTH-1:0] addend,
  output logic signed [ACC_WIDTH-1:0]    result
);

  // One extra bit is enough headroom because the weight is never wider
  // than the accumulator, so the true sum can overflow by at most one bit.
  localparam int SW = ACC_WIDTH + 1;

  localparam logic signed [SW-1:0] MAX_W = SW'(sat_max(ACC_WIDTH));
  localparam logic signed [SW-1:0] MIN_W = SW'(sat_min(ACC_WIDTH));

  logic signed [SW-1:0] acc_wide;
  logic signed [SW-1:0] addend_wide;
  logic signed [SW-1:0] wide_sum;

  // Full-precision sum followed by clamping to the accumulator range.
  always_comb begin
    acc_wide    = {{(SW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    addend_wide = {{(SW - WEIGHT_WIDTH){addend[WEIGHT_WIDTH-1]}}, addend};
    wide_sum    = acc_wide + addend_wide;
    result      = wide_sum[ACC_WIDTH-1:0];
    if (wide_sum > MAX_W) begin
      result = MAX_W[ACC_WIDTH-1:0];
    end else if (wide_sum < MIN_W) begin
      result = MIN_W[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hidden_layer_accumulator.sv
// Hidden-layer accumulator: drains a queue of active input-pixel indices,
// fetches the weight row for each index from a 1-cycle-latency memory and
// adds every node's weight into that node's saturating accumulator.
// Each active index costs four cycles (CHECK, POP, FETCH, ACCUM). Results
// are held with resultsValid until resultsAck is seen in DONE.
// Optional build macro HIDDEN_RELU_EN: when defined, the sums output
// presents max(acc, 0) per node; controller timing is unchanged.
module hidden_layer_accumulator
  import nn_pkg::*;
#(
  parameter int INPUT_LAYER_NODES = DEFAULT_INPUT_LAYER_NODES,
  parameter int HIDDEN_NODES      = DEFAULT_HIDDEN_NODES,
  parameter int WEIGHT_WIDTH      = DEFAULT_WEIGHT_WIDTH,
  parameter int ACC_WIDTH         = DEFAULT_ACC_WIDTH,
  localparam int IDXW = (INPUT_LAYER_NODES > 1) ? $clog2(INPUT_LAYER_NODES) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              outputsReady,
  input  logic                              queueEmpty,
  input  logic [IDXW-1:0]                   indexOut,
  output logic                              dequeue,
  output logic [IDXW-1:0]                   weightAddr,
  input  logic [HIDDEN_NODES*WEIGHT_WIDTH-1:0] weightData,
  output logic [HIDDEN_NODES*ACC_WIDTH-1:0] sums,
  output logic                              resultsValid,
  input  logic                              resultsAck,
  output logic                              busy
);

  state_t state;
  state_t next_state;

  logic signed [ACC_WIDTH-1:0] acc     [HIDDEN_NODES];
  logic signed [ACC_WIDTH-1:0] sat_out [HIDDEN_NODES];

  // One saturating adder per hidden node, each fed by its own weight slice.
  for (genvar k = 0; k < HIDDEN_NODES; k++) begin : g_node
    sat_add #(
      .ACC_WIDTH    (ACC_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_sat_add (
      .acc    (acc[k]),
      .addend (weightData[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .result (sat_out[k])
    );
  end

  // Controller state register; an asserted (low) reset abandons any batch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE waits for a batch, CHECK/POP/FETCH/ACCUM loop
  // once per queued index, DONE holds results until acknowledged.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (outputsReady) begin
          next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (queueEmpty) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_POP;
        end
      end
      ST_POP:   next_state = ST_FETCH;
      ST_FETCH: next_state = ST_ACCUM;
      ST_ACCUM: next_state = ST_CHECK;
      ST_DONE: begin
        if (resultsAck) begin
          next_state = ST_IDLE;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Datapath: clear accumulators at batch start, latch the head index as
  // the weight address in CHECK, and fold the fetched row in during ACCUM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      weightAddr <= '0;
      for (int k = 0; k < HIDDEN_NODES; k++) begin
        acc[k] <= '0;
      end
    end else begin
      if (state == ST_IDLE && outputsReady) begin
        for (int k = 0; k < HIDDEN_NODES; k++) begin
          acc[k] <= '0;
        end
      end
      if (state == ST_CHECK && !queueEmpty) begin
        weightAddr <= indexOut;
      end
      if (state == ST_ACCUM) begin
        for (int k = 0; k < HIDDEN_NODES; k++) begin
          acc[k] <= sat_out[k];
        end
      end
    end
  end

  // Status outputs decode directly from the state, so a reset to IDLE
  // drops them all in the same cycle and no stray pop can follow.
  always_comb begin
    dequeue      = (state == ST_POP);
    resultsValid = (state == ST_DONE);
    busy         = (state != ST_IDLE);
  end

  // Result presentation: raw saturated sums, or clipped at zero when the
  // ReLU build option is enabled.
  always_comb begin
    sums = '0;
    for (int k = 0; k < HIDDEN_NODES; k++) begin
`ifdef HIDDEN_RELU_EN
      if (acc[k][ACC_WIDTH-1]) begin
        sums[k*ACC_WIDTH +: ACC_WIDTH] = '0;
      end else begin
        sums[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
      end
`else
      sums[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
`endif
    end
  end

endmodule

// File: tb/tb_hidden_layer_accumulator.sv
// Self-checking bench for hidden_layer_accumulator (8-bit accumulators so
// saturation is easy to reach). Models the upstream index queue and a
// 1-cycle weight memory, and predicts sums with a plain arithmetic model.
module tb_hidden_layer_accumulator;

  localparam int NODES = 10;
  localparam int HN    = 4;
  localparam int WW    = 8;
  localparam int AW    = 8;
  localparam int IDXW  = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                outputs_ready = 1'b0;
  logic                queue_empty;
  logic [IDXW-1:0]     index_out;
  logic                dequeue;
  logic [IDXW-1:0]     weight_addr;
  logic [HN*WW-1:0]    weight_data = '0;
  logic [HN*AW-1:0]    sums;
  logic                results_valid;
  logic                results_ack = 1'b0;
  logic                busy;

  // Upstream queue: fixed storage, head advanced on dequeue, tail on load.
  logic [IDXW-1:0] q_mem [0:255];
  int              q_head = 0;
  int              q_tail = 0;
  logic            flush = 1'b0;
  int              deq_count = 0;

  // Weight memory contents, one signed byte per (pixel, node).
  logic signed [WW-1:0] wmem [0:NODES-1][0:HN-1];

  int errors = 0;
  int checks = 0;
  int batch[$];
  int exp_sums[HN];

  hidden_layer_accumulator #(
    .INPUT_LAYER_NODES (NODES),
    .HIDDEN_NODES      (HN),
    .WEIGHT_WIDTH      (WW),
    .ACC_WIDTH         (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .outputsReady (outputs_ready),
    .queueEmpty   (queue_empty),
    .indexOut     (index_out),
    .dequeue      (dequeue),
    .weightAddr   (weight_addr),
    .weightData   (weight_data),
    .sums         (sums),
    .resultsValid (results_valid),
    .resultsAck   (results_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign queue_empty = (q_head == q_tail);
  assign index_out   = q_mem[q_head[7:0]];

  // Upstream queue pops and weight memory reads happen on the rising edge.
  always @(posedge clk) begin
    if (dequeue) deq_count <= deq_count + 1;
    if (flush) q_head <= q_tail;
    else if (dequeue && q_head != q_tail) q_head <= q_head + 1;
    for (int k = 0; k < HN; k++) begin
      if (int'(weight_addr) < NODES) weight_data[k*WW +: WW] <= wmem[weight_addr][k];
      else weight_data[k*WW +: WW] <= '0;
    end
  end

  function automatic int node_sum(input int k);
    logic signed [AW-1:0] v;
    v = sums[k*AW +: AW];
    return int'(v);
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: every queued entry adds its weight row once, clamping per add.
  task automatic computeExpected();
    for (int k = 0; k < HN; k++) exp_sums[k] = 0;
    foreach (batch[i])
      for (int k = 0; k < HN; k++) exp_sums[k] = clamp(exp_sums[k] + int'(wmem[batch[i]][k]));
`ifdef HIDDEN_RELU_EN
    for (int k = 0; k < HN; k++) if (exp_sums[k] < 0) exp_sums[k] = 0;
`endif
  endtask

  task automatic waitDone(output int cycles, input bit random_ack);
    cycles = 0;
    while (!results_valid && cycles < 400) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (random_ack) results_ack = 1'($urandom);
    end
    results_ack = 1'b0;
  endtask

  // Loads the batch upstream, starts it, and checks latency, sums and pops.
  task automatic applyStimulus(input string tag, input bit random_ack);
    int cycles;
    int deq_before;
    foreach (batch[i]) begin
      q_mem[q_tail[7:0]] = batch[i][IDXW-1:0];
      q_tail++;
    end
    computeExpected();
    deq_before = deq_count;
    outputs_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outputs_ready = 1'b0;
    waitDone(cycles, random_ack);
    checkOutput({tag, "_latency"}, cycles, 4 * batch.size() + 1);
    checkOutput({tag, "_valid"}, int'(results_valid), 1);
    for (int k = 0; k < HN; k++)
      checkOutput($sformatf("%s_sum%0d", tag, k), node_sum(k), exp_sums[k]);
    checkOutput({tag, "_pops"}, deq_count - deq_before, batch.size());
  endtask

  task automatic ackResults(input string tag);
    results_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    results_ack = 1'b0;
    checkOutput({tag, "_ack_busy"}, int'(busy), 0);
    checkOutput({tag, "_ack_valid"}, int'(results_valid), 0);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(results_valid), 0);
    checkOutput("rst_dequeue", int'(dequeue), 0);
    checkOutput("rst_addr", int'(weight_addr), 0);
    checkOutput("rst_sums", int'(sums), 0);
    reset = 1'b1;
    @(negedge clk);

    // Reference batch 2,4,5,7,9: node0=i, node1=-i, others 1.
    for (int i = 0; i < NODES; i++) begin
      wmem[i][0] = WW'(i);
      wmem[i][1] = WW'(-i);
      wmem[i][2] = 8'sd1;
      wmem[i][3] = 8'sd1;
    end
    batch = '{2, 4, 5, 7, 9};
    applyStimulus("ref", 1'b0);
    checkOutput("ref_const_sum0", node_sum(0), 27);
    ackResults("ref");

    // Empty batch.
    batch = {};
    applyStimulus("empty", 1'b0);
    ackResults("empty");

    // Saturation at both limits over all ten pixels.
    for (int i = 0; i < NODES; i++) for (int k = 0; k < HN; k++) wmem[i][k] = 8'sd127;
    batch = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    applyStimulus("satpos", 1'b0);
    ackResults("satpos");
    for (int i = 0; i < NODES; i++) for (int k = 0; k < HN; k++) wmem[i][k] = -8'sd128;
    applyStimulus("satneg", 1'b0);
    ackResults("satneg");

    // Handshake: results held for 50 cycles while outputsReady is ignored.
    for (int i = 0; i < NODES; i++) for (int k = 0; k < HN; k++) wmem[i][k] = WW'($urandom);
    batch = '{3, 3, 8, 1};
    applyStimulus("hold", 1'b0);
    outputs_ready = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c % 10 == 0) begin
        checkOutput("hold_valid", int'(results_valid), 1);
        checkOutput("hold_busy", int'(busy), 1);
        for (int k = 0; k < HN; k++) checkOutput($sformatf("hold_sum%0d", k), node_sum(k), exp_sums[k]);
      end
    end
    outputs_ready = 1'b0;
    ackResults("hold");
    batch = '{6, 0};
    applyStimulus("after_hold", 1'b0);
    ackResults("after_hold");

    // Randomized batches with stray acks while busy.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NODES; i++) for (int k = 0; k < HN; k++) wmem[i][k] = WW'($urandom);
      batch = {};
      n = $urandom_range(0, 12);
      for (int j = 0; j < n; j++) batch.push_back($urandom_range(0, NODES - 1));
      applyStimulus($sformatf("rand%0d", t), 1'b1);
      ackResults($sformatf("rand%0d", t));
    end

    // Reset during the third index's FETCH.
    batch = '{1, 2, 3, 4, 5};
    foreach (batch[i]) begin
      q_mem[q_tail[7:0]] = batch[i][IDXW-1:0];
      q_tail++;
    end
    n = deq_count;
    outputs_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outputs_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(results_valid), 0);
    checkOutput("midrst_dequeue", int'(dequeue), 0);
    checkOutput("midrst_addr", int'(weight_addr), 0);
    checkOutput("midrst_sums", int'(sums), 0);
    checkOutput("midrst_pops", deq_count - n, 3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("postrst_pops", deq_count - n, 3);
    checkOutput("postrst_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
